// File: rtl/wallace_multiplier.sv
// Unsigned 4x4 Wallace-tree multiplier: two 3:2/2:2 reduction levels, a ripple
// carry-propagate adder and a registered 8-bit product.
module wallace_ha (
   input  logic x,
   input  logic y,
   output logic sum,
   output logic carry
);
   assign sum   = x ^ y;
   assign carry = x & y;
endmodule

module wallace_fa (
   input  logic x,
   input  logic y,
   input  logic z,
   output logic sum,
   output logic carry
);
   assign sum   = x ^ y ^ z;
   assign carry = (x & y) | (x & z) | (y & z);
endmodule

module wallace_multiplier (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] pro
);
   // pp[i][j] carries weight 2^(i+j)
   logic [3:0][3:0] pp;
   logic [7:0]      prod;

   for (genvar i = 0; i < 4; i++) begin : g_row
      for (genvar j = 0; j < 4; j++) begin : g_col
         assign pp[i][j] = a[j] & b[i];
      end
   end

   // level 1: column heights 1,2,3,4,3,2,1 -> 1,1,2,3,2,2,2
   logic s1_1, c1_1, s1_2, c1_2, s1_3, c1_3, s1_4, c1_4, s1_5, c1_5;

   wallace_ha h1_1 (.x(pp[0][1]), .y(pp[1][0]), .sum(s1_1), .carry(c1_1));
   wallace_fa f1_2 (.x(pp[0][2]), .y(pp[1][1]), .z(pp[2][0]), .sum(s1_2), .carry(c1_2));
   wallace_fa f1_3 (.x(pp[0][3]), .y(pp[1][2]), .z(pp[2][1]), .sum(s1_3), .carry(c1_3));
   wallace_fa f1_4 (.x(pp[1][3]), .y(pp[2][2]), .z(pp[3][1]), .sum(s1_4), .carry(c1_4));
   wallace_ha h1_5 (.x(pp[2][3]), .y(pp[3][2]), .sum(s1_5), .carry(c1_5));

   // level 2: every column ends with at most two bits; column 7 gets one
   logic s2_3, c2_3, s2_4, c2_4, s2_5, c2_5, s2_6, c2_6;

   wallace_fa f2_3 (.x(s1_3), .y(pp[3][0]), .z(c1_2), .sum(s2_3), .carry(c2_3));
   wallace_ha h2_4 (.x(s1_4), .y(c1_3), .sum(s2_4), .carry(c2_4));
   wallace_ha h2_5 (.x(s1_5), .y(c1_4), .sum(s2_5), .carry(c2_5));
   wallace_ha h2_6 (.x(pp[3][3]), .y(c1_5), .sum(s2_6), .carry(c2_6));

   // final ripple adder over columns 2..7
   logic r2, r3, r4, r5, r6;

   assign prod[0] = pp[0][0];
   assign prod[1] = s1_1;
   wallace_ha ha_2 (.x(s1_2), .y(c1_1), .sum(prod[2]), .carry(r2));
   wallace_ha ha_3 (.x(s2_3), .y(r2), .sum(prod[3]), .carry(r3));
   wallace_fa fa_4 (.x(s2_4), .y(c2_3), .z(r3), .sum(prod[4]), .carry(r4));
   wallace_fa fa_5 (.x(s2_5), .y(c2_4), .z(r4), .sum(prod[5]), .carry(r5));
   wallace_fa fa_6 (.x(s2_6), .y(c2_5), .z(r5), .sum(prod[6]), .carry(r6));
   // c2_6 and r6 are never both set since 15*15 < 256, so xor is exact here
   assign prod[7] = c2_6 ^ r6;

   always_ff @(posedge clk) begin
      if (rst) pro <= 8'h00;
      else     pro <= prod;
   end
endmodule

// File: tb/tb_wallace_multiplier.sv
// Table-driven and exhaustive check of wallace_multiplier with a scoreboard queue.
module tb_wallace_multiplier;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] a = 4'h0;
   logic [3:0] b = 4'h0;
   logic [7:0] pro;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] exp_q[$];

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       rst;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl[14];

   wallace_multiplier dut (.clk(clk), .rst(rst), .a(a), .b(b), .pro(pro));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] want);
      n_cmp++;
      if (pro !== want) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", name, pro, want);
      end
   endtask

   // drive one operand pair, queue its expected product, compare after the edge
   task automatic apply(input string name, input logic [3:0] ta, input logic [3:0] tb,
                        input logic tr, input logic [7:0] e);
      logic [7:0] want;
      @(negedge clk);
      a = ta; b = tb; rst = tr;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         n_cmp++; n_bad++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         want = exp_q.pop_front();
         check(name, want);
      end
   endtask

   initial begin
      tbl[0]  = '{4'hF, 4'hF, 1'b1, 8'h00};
      tbl[1]  = '{4'hF, 4'hF, 1'b1, 8'h00};
      tbl[2]  = '{4'hF, 4'hF, 1'b0, 8'hE1};
      tbl[3]  = '{4'd0, 4'd13, 1'b0, 8'd0};
      tbl[4]  = '{4'd1, 4'd13, 1'b0, 8'd13};
      tbl[5]  = '{4'd9, 4'd1, 1'b0, 8'd9};
      tbl[6]  = '{4'd15, 4'd15, 1'b0, 8'd225};
      tbl[7]  = '{4'd8, 4'd8, 1'b0, 8'd64};
      tbl[8]  = '{4'd15, 4'd1, 1'b0, 8'd15};
      tbl[9]  = '{4'd7, 4'd9, 1'b0, 8'd63};
      tbl[10] = '{4'd12, 4'd11, 1'b0, 8'd132};
      tbl[11] = '{4'd3, 4'd5, 1'b0, 8'd15};
      tbl[12] = '{4'd6, 4'd7, 1'b0, 8'd42};
      tbl[13] = '{4'd10, 4'd10, 1'b0, 8'd100};

      for (int k = 0; k < 14; k++)
         apply($sformatf("tbl%0d", k), tbl[k].a, tbl[k].b, tbl[k].rst, tbl[k].exp);

      // reset on the cycle 10*10 is applied, then the stream resumes
      apply("b2b_3x5", 4'd3, 4'd5, 1'b0, 8'd15);
      apply("b2b_6x7", 4'd6, 4'd7, 1'b0, 8'd42);
      apply("b2b_rst", 4'd10, 4'd10, 1'b1, 8'd0);
      apply("b2b_2x3", 4'd2, 4'd3, 1'b0, 8'd6);
      apply("b2b_4x4", 4'd4, 4'd4, 1'b0, 8'd16);

      // reset raised between edges must not disturb pro until the next edge
      apply("mid_pre", 4'd5, 4'd5, 1'b0, 8'd25);
      #2 rst = 1'b1;
      #1 check("mid_hold", 8'd25);
      @(posedge clk);
      #1 check("mid_clr", 8'd0);
      apply("mid_rel", 4'd11, 4'd13, 1'b0, 8'd143);

      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++)
            apply($sformatf("exh_%0dx%0d", i, j), i[3:0], j[3:0], 1'b0, 8'(i * j));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/wallace_multiplier.md
# wallace_multiplier

Unsigned 4x4-bit multiplier built as a Wallace-tree reduction of partial products followed by a final carry-propagate adder. The 8-bit product is registered, so it drops into a synchronous datapath. It is a leaf arithmetic block: no handshake, a new operand pair is accepted every cycle.

## Interface

- No parameters; widths are fixed at 4x4 -> 8.
- clk  input  1  rising-edge clock for the output register.
- rst  input  1  synchronous, active-high reset; clears the product register.
- a  input  4  multiplicand, unsigned.
- b  input  4  multiplier, unsigned.
- pro  output  8  registered product a*b, unsigned.

## Operation

- Partial products: pp[i][j] = a[j] & b[i] for i, j in 0..3. This gives 16 bits of weight 2^(i+j).
- Column heights by weight 0..6 are 1,2,3,4,3,2,1.
- Reduction stage 1 (Wallace):
  - Apply full adders (3:2) and half adders (2:2) per column.
  - Each FA/HA sum stays in its column; each carry moves to column+1.
- Reduction stage 2: repeat the same until every column holds at most 2 bits.
- Final adder: ripple-carry addition of the two remaining rows, producing the 8-bit result.
  - Bit 7 is the final carry-out.
  - No bits are dropped: 15*15 = 225 fits in 8 bits.
- Building blocks:
  - Half-adder and full-adder submodules, instantiated structurally.
  - The behavioural `*` operator must not appear in the datapath.
- Arithmetic: purely unsigned; result is exact for all 256 operand pairs; no overflow or saturation.
- Output register:
  - At each rising clk edge, pro <= rst ? 8'h00 : (combinational product of the current a, b).
- Combinational path: no state besides the output register; a and b are not registered inside the block.

## Timing

- Latency: 1 clock. Operands stable before rising edge N give pro valid after edge N, held until edge N+1.
- Throughput: one product per clock; back-to-back operand changes are allowed every cycle.
- Reset:
  - pro = 8'h00 after any rising edge with rst=1, regardless of a and b.
  - Reset is synchronous: asserting rst between edges does not change pro until the next edge.
  - The first edge with rst=0 loads the product of the operands present at that edge.
- Reset mid-operation: a pending product is discarded; no other state needs recovery.
- X-handling: none required. Operands are assumed driven before the first edge after reset release.
- The combinational depth must close at the target clock:
  - Two reduction levels plus the final ripple adder.
  - At most 6 FA-equivalent delays on the final adder.

## Test plan

- Reset: rst=1 for 2 edges with a=4'hF, b=4'hF -> pro=8'h00. Release rst -> pro=8'hE1 (225) after the next edge.
- Zero and identity:
  - a=0, b=13 -> pro=0.
  - a=1, b=13 -> pro=13.
  - a=9, b=1 -> pro=9.
  - Each result appears exactly 1 cycle after the operands are applied.
- Carry-heavy corners:
  - a=15, b=15 -> 225.
  - a=8, b=8 -> 64.
  - a=15, b=1 -> 15.
  - a=7, b=9 -> 63.
  - a=12, b=11 -> 132 (exercises bit 7).
- Exhaustive: loop i, j over 0..15 (256 pairs), one pair per cycle. Compare pro against the reference value i*j delayed by 1 cycle; zero mismatches required.
- Back-to-back plus mid-stream reset:
  - Apply 3*5, 6*7, 10*10 on consecutive cycles -> 15, 42, 100 on consecutive cycles.
  - Assert rst on the cycle 10*10 is applied -> pro=0 instead of 100, then the normal stream resumes.
